// File: rtl/fhn_spike_detector.sv
// Spike detector for the FHN neuron core: hysteretic threshold with debounce and refractory
// window, spike count, inter-spike interval and a FWFT timestamp FIFO.
module fhn_spike_detector #(
  parameter int                     DW          = 16,
  parameter logic signed [DW-1:0]   V_HI        = 16'sd4096,
  parameter logic signed [DW-1:0]   V_LO        = 16'sd0,
  parameter int                     DEBOUNCE    = 2,
  parameter int                     REFRACT_CYC = 16,
  parameter int                     TSW         = 32,
  parameter int                     FIFO_DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic signed [DW-1:0]  v,
  output logic                  spike,
  output logic [TSW-1:0]        spike_count,
  output logic [TSW-1:0]        isi,
  output logic                  isi_valid,
  output logic                  ev_valid,
  output logic [TSW-1:0]        ev_data,
  input  logic                  ev_rd,
  output logic                  ev_overflow,
  output logic [1:0]            state_o
);

  localparam int DBW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
  localparam int RW  = $clog2(REFRACT_CYC + 1);
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    BELOW   = 2'b00,
    ABOVE   = 2'b01,
    REFRACT = 2'b10
  } state_t;

  state_t          state, state_nx;
  logic [DBW-1:0]  dbc, dbc_nx;
  logic [RW-1:0]   rc, rc_nx;
  logic            fire;
  logic            ge_hi, le_lo;

  logic [TSW-1:0]  ts;
  logic [TSW-1:0]  last_ts;
  logic            seen_first;

  logic [TSW-1:0]  mem [FIFO_DEPTH];
  logic [AW:0]     wp, rp;
  logic            empty, full, pop, push;

  assign ge_hi   = (v >= V_HI);
  assign le_lo   = (v <= V_LO);
  assign state_o = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BELOW;
      dbc   <= '0;
      rc    <= '0;
    end else begin
      state <= state_nx;
      dbc   <= dbc_nx;
      rc    <= rc_nx;
    end
  end

  // REFRACT exits on the enabled cycle that consumes the last count, so exactly
  // REFRACT_CYC enabled samples are spent there.
  always_comb begin
    state_nx = state;
    dbc_nx   = dbc;
    rc_nx    = rc;
    fire     = 1'b0;
    if (en) begin
      case (state)
        BELOW: begin
          if (ge_hi) begin
            if (dbc == DBW'(DEBOUNCE - 1)) begin
              fire     = 1'b1;
              state_nx = ABOVE;
              dbc_nx   = '0;
            end else begin
              dbc_nx = dbc + 1'b1;
            end
          end else begin
            dbc_nx = '0;
          end
        end
        ABOVE: begin
          if (le_lo) begin
            state_nx = REFRACT;
            rc_nx    = RW'(REFRACT_CYC);
          end
        end
        REFRACT: begin
          if (rc <= RW'(1)) begin
            state_nx = BELOW;
            rc_nx    = '0;
          end else begin
            rc_nx = rc - 1'b1;
          end
        end
        default: state_nx = BELOW;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts          <= '0;
      spike       <= 1'b0;
      spike_count <= '0;
      isi         <= '0;
      isi_valid   <= 1'b0;
      last_ts     <= '0;
      seen_first  <= 1'b0;
    end else begin
      ts    <= ts + 1'b1;
      spike <= fire;
      if (fire) begin
        spike_count <= spike_count + 1'b1;
        isi         <= ts - last_ts;
        last_ts     <= ts;
        seen_first  <= 1'b1;
        if (seen_first) isi_valid <= 1'b1;
      end
    end
  end

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty    = (wp == rp);
  assign full     = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop      = ev_rd && !empty;
  assign push     = fire && (!full || pop);
  assign ev_valid = !empty;
  assign ev_data  = empty ? '0 : mem[rp[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp          <= '0;
      rp          <= '0;
      ev_overflow <= 1'b0;
    end else begin
      if (pop)  rp <= rp + 1'b1;
      if (push) wp <= wp + 1'b1;
      if (fire && full && !pop) ev_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= ts;
  end

endmodule

// File: tb/tb_fhn_spike_detector.sv
// Self-checking bench for fhn_spike_detector: directed scenarios plus random stimulus
// compared against a behavioural model built from the detector's rules.
module tb_fhn_spike_detector;

  localparam logic signed [15:0] V_HI = 16'sd4096;
  localparam int DEB   = 2;
  localparam int RCYC  = 16;
  localparam int DEPTH = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic signed [15:0] v;
  logic               ev_rd;
  logic               spike;
  logic [31:0]        spike_count;
  logic [31:0]        isi;
  logic               isi_valid;
  logic               ev_valid;
  logic [31:0]        ev_data;
  logic               ev_overflow;
  logic [1:0]         state_o;

  int errors = 0;
  int checks = 0;

  fhn_spike_detector #(
    .DW(16), .V_HI(16'sd4096), .V_LO(16'sd0), .DEBOUNCE(DEB),
    .REFRACT_CYC(RCYC), .TSW(32), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .v(v), .spike(spike),
    .spike_count(spike_count), .isi(isi), .isi_valid(isi_valid),
    .ev_valid(ev_valid), .ev_data(ev_data), .ev_rd(ev_rd),
    .ev_overflow(ev_overflow), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Behavioural model: state 0 below, 1 above, 2 refractory
  int          m_st, m_hits, m_rdone, m_nsp;
  logic [31:0] m_ts, m_count, m_isi, m_last;
  logic        m_spike, m_isiv, m_ovf;
  logic [31:0] m_q[$];

  task automatic m_clear();
    m_st = 0; m_hits = 0; m_rdone = 0; m_nsp = 0;
    m_ts = '0; m_count = '0; m_isi = '0; m_last = '0;
    m_spike = 1'b0; m_isiv = 1'b0; m_ovf = 1'b0;
    m_q.delete();
  endtask

  task automatic tick(input logic e, input logic signed [15:0] vv, input logic r);
    bit fire, popq;
    en = e; v = vv; ev_rd = r;
    @(posedge clk);
    popq = r && (m_q.size() != 0);
    fire = e && (m_st == 0) && (vv >= V_HI) && (m_hits + 1 == DEB);
    m_spike = fire;
    if (popq) void'(m_q.pop_front());
    if (fire) begin
      m_count = m_count + 1;
      m_isi   = m_ts - m_last;
      m_last  = m_ts;
      m_nsp++;
      if (m_nsp >= 2) m_isiv = 1'b1;
      if (m_q.size() == DEPTH) m_ovf = 1'b1;
      else m_q.push_back(m_ts);
    end
    if (e) begin
      if (m_st == 0) begin
        if (fire) begin m_st = 1; m_hits = 0; end
        else if (vv >= V_HI) m_hits++;
        else m_hits = 0;
      end else if (m_st == 1) begin
        if (vv <= 0) begin m_st = 2; m_rdone = 0; end
      end else begin
        m_rdone++;
        if (m_rdone == RCYC) m_st = 0;
      end
    end
    m_ts = m_ts + 1;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; v = '0; ev_rd = 1'b0;
    m_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One complete spike cycle: fire, re-arm, full refractory window.
  task automatic spike_cycle(input logic rd_on_fire);
    tick(1, 16'sd4096, 0);
    tick(1, 16'sd4096, rd_on_fire);
    tick(1, -16'sd100, 0);
    repeat (RCYC) tick(1, 16'sd0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; v = '0; ev_rd = 1'b0;
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (spike !== 1'b0) begin errors++; $display("FAIL reset_spike got=%0b exp=0", spike); end
    checks++; if (spike_count !== 32'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", spike_count); end
    checks++; if (isi !== 32'd0 || isi_valid !== 1'b0) begin errors++; $display("FAIL reset_isi got=%0d/%0b exp=0/0", isi, isi_valid); end
    checks++; if (ev_valid !== 1'b0 || ev_data !== 32'd0 || ev_overflow !== 1'b0) begin errors++; $display("FAIL reset_fifo got=%0b/%0d/%0b exp=0/0/0", ev_valid, ev_data, ev_overflow); end
    checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    rst = 1'b0;
  endtask

  task automatic test_ramp();
    logic [31:0] t_fire;
    repeat (10) begin
      tick(1, 16'sd0, 0);
      checks++; if (spike !== 1'b0) begin errors++; $display("FAIL ramp_quiet got=%0b exp=0", spike); end
    end
    tick(1, 16'sd4096, 0);
    checks++; if (spike !== 1'b0 || state_o !== 2'b00) begin errors++; $display("FAIL ramp_first got=%0b/%0d exp=0/0", spike, state_o); end
    t_fire = m_ts;
    tick(1, 16'sd4096, 0);
    checks++; if (spike !== 1'b1) begin errors++; $display("FAIL ramp_spike got=%0b exp=1", spike); end
    checks++; if (spike_count !== 32'd1) begin errors++; $display("FAIL ramp_count got=%0d exp=1", spike_count); end
    checks++; if (ev_valid !== 1'b1 || ev_data !== t_fire) begin errors++; $display("FAIL ramp_ev got=%0b/%0d exp=1/%0d", ev_valid, ev_data, t_fire); end
    checks++; if (isi_valid !== 1'b0 || state_o !== 2'b01) begin errors++; $display("FAIL ramp_isiv_state got=%0b/%0d exp=0/1", isi_valid, state_o); end
    tick(1, 16'sd4096, 0);
    checks++; if (spike !== 1'b0) begin errors++; $display("FAIL ramp_pulse_width got=%0b exp=0", spike); end
  endtask

  task automatic test_glitch();
    tick(1, -16'sd100, 0);
    repeat (RCYC) tick(1, 16'sd0, 0);
    checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL glitch_rearm got=%0d exp=0", state_o); end
    repeat (20) begin
      tick(1, 16'sd4096, 0);
      tick(1, 16'sd2048, 0);
      checks++; if (spike !== 1'b0 || state_o !== 2'b00) begin errors++; $display("FAIL glitch_nospike got=%0b/%0d exp=0/0", spike, state_o); end
    end
    checks++; if (spike_count !== 32'd1) begin errors++; $display("FAIL glitch_count got=%0d exp=1", spike_count); end
  endtask

  task automatic test_hyst_refract();
    tick(1, 16'sd4096, 0);
    tick(1, 16'sd4096, 0);
    checks++; if (spike !== 1'b1) begin errors++; $display("FAIL hyst_fire got=%0b exp=1", spike); end
    repeat (50) begin
      tick(1, 16'sd2048, 0);
      checks++; if (spike !== 1'b0 || state_o !== 2'b01) begin errors++; $display("FAIL hyst_hold got=%0b/%0d exp=0/1", spike, state_o); end
    end
    tick(1, -16'sd100, 0);
    checks++; if (state_o !== 2'b10) begin errors++; $display("FAIL hyst_refract got=%0d exp=2", state_o); end
    for (int i = 1; i <= RCYC; i++) begin
      tick(1, (i >= 10) ? 16'sd4096 : 16'sd0, 0);
      checks++; if (spike !== 1'b0 || state_o !== 2'(m_st)) begin errors++; $display("FAIL refract_cyc%0d got=%0b/%0d exp=0/%0d", i, spike, state_o, m_st); end
    end
    checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL refract_end got=%0d exp=0", state_o); end
    tick(1, 16'sd4096, 0);
    checks++; if (spike !== 1'b0) begin errors++; $display("FAIL rearm_first got=%0b exp=0", spike); end
    tick(1, 16'sd4096, 0);
    checks++; if (spike !== 1'b1 || isi !== m_isi || isi_valid !== 1'b1) begin errors++; $display("FAIL rearm_spike got=%0b/%0d/%0b exp=1/%0d/1", spike, isi, isi_valid, m_isi); end
  endtask

  task automatic test_periodic();
    int n = 0;
    logic [31:0] prev;
    prev = spike_count;
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 80; k++) begin
        tick(1, (k < 40) ? -16'sd6000 : 16'sd6000, 1);
        if (spike === 1'b1) begin
          n++;
          checks++; if (spike_count !== prev + 1) begin errors++; $display("FAIL periodic_count got=%0d exp=%0d", spike_count, prev + 1); end
          prev = spike_count;
          if (n > 1) begin
            checks++; if (isi !== 32'd80 || isi_valid !== 1'b1) begin errors++; $display("FAIL periodic_isi got=%0d/%0b exp=80/1", isi, isi_valid); end
          end
        end
      end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL periodic_nspikes got=%0d exp=4", n); end
    checks++; if (ev_overflow !== 1'b0) begin errors++; $display("FAIL periodic_ovf got=%0b exp=0", ev_overflow); end
  endtask

  task automatic test_fifo();
    logic [31:0] fired[$];
    do_reset();
    for (int s = 0; s < 10; s++) begin
      spike_cycle(0);
      fired.push_back(m_last);
    end
    checks++; if (ev_overflow !== 1'b1) begin errors++; $display("FAIL fifo_ovf got=%0b exp=1", ev_overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (ev_valid !== 1'b1 || ev_data !== fired[i]) begin errors++; $display("FAIL fifo_rd%0d got=%0b/%0d exp=1/%0d", i, ev_valid, ev_data, fired[i]); end
      tick(0, 16'sd0, 1);
    end
    checks++; if (ev_valid !== 1'b0 || ev_data !== 32'd0) begin errors++; $display("FAIL fifo_drained got=%0b/%0d exp=0/0", ev_valid, ev_data); end
    tick(0, 16'sd0, 1);
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL fifo_rd_empty got=%0b exp=0", ev_valid); end

    do_reset();
    fired.delete();
    for (int s = 0; s < 9; s++) begin
      spike_cycle(s == 8);
      fired.push_back(m_last);
    end
    checks++; if (ev_overflow !== 1'b0) begin errors++; $display("FAIL fifo_pushpop_ovf got=%0b exp=0", ev_overflow); end
    for (int i = 1; i <= DEPTH; i++) begin
      checks++; if (ev_valid !== 1'b1 || ev_data !== fired[i]) begin errors++; $display("FAIL fifo_pp_rd%0d got=%0b/%0d exp=1/%0d", i, ev_valid, ev_data, fired[i]); end
      tick(0, 16'sd0, 1);
    end
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL fifo_pp_drained got=%0b exp=0", ev_valid); end
  endtask

  task automatic test_async_reset();
    logic [31:0] t0;
    do_reset();
    spike_cycle(0);
    spike_cycle(0);
    tick(1, 16'sd4096, 0);
    tick(1, 16'sd4096, 0);
    tick(1, -16'sd100, 0);
    repeat (3) tick(1, 16'sd0, 0);
    checks++; if (state_o !== 2'b10 || ev_valid !== 1'b1) begin errors++; $display("FAIL pre_reset got=%0d/%0b exp=2/1", state_o, ev_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (state_o !== 2'b00 || spike_count !== 32'd0 || isi !== 32'd0 || isi_valid !== 1'b0) begin errors++; $display("FAIL async_core got=%0d/%0d/%0d/%0b exp=0/0/0/0", state_o, spike_count, isi, isi_valid); end
    checks++; if (ev_valid !== 1'b0 || ev_data !== 32'd0 || ev_overflow !== 1'b0) begin errors++; $display("FAIL async_fifo got=%0b/%0d/%0b exp=0/0/0", ev_valid, ev_data, ev_overflow); end
    m_clear();
    @(posedge clk); #1 rst = 1'b0;

    tick(1, 16'sd4096, 0);
    tick(1, 16'sd4096, 0);
    checks++; if (spike !== 1'b1) begin errors++; $display("FAIL inflight_pre got=%0b exp=1", spike); end
    #2 rst = 1'b1;
    #1;
    checks++; if (spike !== 1'b0 || spike_count !== 32'd0) begin errors++; $display("FAIL inflight_kill got=%0b/%0d exp=0/0", spike, spike_count); end
    m_clear();
    @(posedge clk); #1 rst = 1'b0;

    t0 = m_ts;
    tick(1, 16'sd4096, 0);
    for (int i = 0; i < 10; i++) begin
      tick(0, -16'sd100, 0);
      checks++; if (state_o !== 2'b00 || spike !== 1'b0) begin errors++; $display("FAIL freeze%0d got=%0d/%0b exp=0/0", i, state_o, spike); end
    end
    tick(1, 16'sd4096, 0);
    checks++; if (spike !== 1'b1 || ev_data !== t0 + 32'd11) begin errors++; $display("FAIL freeze_fire got=%0b/%0d exp=1/%0d", spike, ev_data, t0 + 32'd11); end
  endtask

  task automatic test_random();
    logic signed [15:0] vv;
    logic e, r;
    int sel;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: vv = 16'sd4096;
        1: vv = 16'sd4095;
        2: vv = 16'sd0;
        3: vv = 16'($urandom_range(4096, 8000));
        default: vv = 16'(int'($urandom_range(0, 12000)) - 8000);
      endcase
      e = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 11) == 0);
      tick(e, vv, r);
      checks++; if (spike !== m_spike) begin errors++; $display("FAIL rnd_spike@%0d got=%0b exp=%0b", i, spike, m_spike); end
      checks++; if (state_o !== 2'(m_st)) begin errors++; $display("FAIL rnd_state@%0d got=%0d exp=%0d", i, state_o, m_st); end
      checks++; if (spike_count !== m_count) begin errors++; $display("FAIL rnd_count@%0d got=%0d exp=%0d", i, spike_count, m_count); end
      checks++; if (isi !== m_isi || isi_valid !== m_isiv) begin errors++; $display("FAIL rnd_isi@%0d got=%0d/%0b exp=%0d/%0b", i, isi, isi_valid, m_isi, m_isiv); end
      checks++; if (ev_valid !== (m_q.size() != 0) || ev_data !== ((m_q.size() != 0) ? m_q[0] : 32'd0)) begin errors++; $display("FAIL rnd_ev@%0d got=%0b/%0d", i, ev_valid, ev_data); end
      checks++; if (ev_overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf@%0d got=%0b exp=%0b", i, ev_overflow, m_ovf); end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_glitch();
    test_hyst_refract();
    test_periodic();
    test_fifo();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fhn_spike_detector.md
Name: fhn_spike_detector

Overview:
- Sits directly downstream of the FHN neuron core and consumes its signed Q3.12 membrane potential `v`.
- Detects action potentials using a hysteretic threshold, a debounce count and a refractory window.
- Emits a one-cycle spike pulse, a running spike count and the inter-spike interval (ISI).
- Buffers spike timestamps in a small first-word-fall-through (FWFT) FIFO for a host/readout stage.

Parameters:
- DW, 16, width of `v` (signed, Q3.12, 12 fractional bits).
- V_HI, 16'sd4096, upper threshold (+1.0); a spike requires v >= V_HI.
- V_LO, 16'sd0, lower re-arm threshold (0.0); V_LO < V_HI is required.
- DEBOUNCE, 2, consecutive enabled samples with v >= V_HI needed to fire (>= 1).
- REFRACT_CYC, 16, enabled cycles spent in REFRACT after re-arm (>= 1).
- TSW, 32, width of timestamp, ISI and spike counter.
- FIFO_DEPTH, 8, timestamp FIFO entries (power of 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  sample-enable; `v` is valid when en=1.
- v  in  DW  signed membrane potential from the core.
- spike  out  1  one-cycle pulse per detected spike.
- spike_count  out  TSW  spikes detected since reset; wraps.
- isi  out  TSW  timestamp difference between the last two spikes, modulo 2^TSW.
- isi_valid  out  1  high once at least two spikes have been seen since reset.
- ev_valid  out  1  FIFO non-empty.
- ev_data  out  TSW  head timestamp (FWFT).
- ev_rd  in  1  pop request; acts only when ev_valid=1.
- ev_overflow  out  1  sticky; a spike timestamp was dropped because the FIFO was full.
- state_o  out  2  current FSM state (00 BELOW, 01 ABOVE, 10 REFRACT).

Behaviour:
- Reset (asynchronous): state=BELOW; debounce counter and refractory counter = 0; timestamp counter ts = 0; spike=0; spike_count=0; isi=0; isi_valid=0; FIFO empty (ev_valid=0, ev_data=0); ev_overflow=0.
- Timestamp counter:
  - ts increments every clk cycle regardless of `en`.
  - Wraps from 2^TSW-1 to 0.
- Comparisons are signed, full DW width. When en=0, FSM and counters hold; only ts advances.
- BELOW state:
  - An enabled sample with v >= V_HI increments the debounce counter (dbc); an enabled sample below V_HI clears dbc.
  - On the edge that takes the DEBOUNCE-th consecutive qualifying sample: spike=1 for exactly the next cycle, spike_count+1, state->ABOVE, dbc cleared, and ts (pre-increment value at that edge) is pushed to the FIFO.
- ABOVE state:
  - No further spikes can fire.
  - An enabled sample with v <= V_LO moves to REFRACT and loads the refractory counter with REFRACT_CYC.
- REFRACT state:
  - Counter decrements on enabled cycles; at 0 -> BELOW.
  - Samples >= V_HI during REFRACT are ignored and do not accumulate dbc.
- ISI:
  - On each spike, isi <= ts - last_ts (mod 2^TSW), then last_ts <= ts.
  - isi_valid is set on the second spike after reset and stays set; isi is updated in the same edge as the spike pulse.
- FIFO:
  - Push on spike; pop when ev_rd && ev_valid. ev_rd while empty is ignored.
  - Full with push and no pop: the entry is dropped, ev_overflow set (cleared only by rst), contents unchanged.
  - Full with push and pop in the same cycle: both occur, no drop.
  - Empty with push: ev_valid rises the next cycle and ev_data equals the pushed value (no bypass in the same cycle).
- Reset asserted mid-operation (e.g. in REFRACT or with the FIFO partly full) clears everything immediately. An in-flight spike pulse is terminated.
- Latency: last qualifying sample edge -> spike, isi, spike_count and FIFO write all visible in the following cycle.

Test Plan:
- Ramp: en=1, v=0 for 10 cycles, then v=4096 held -> spike on the 2nd qualifying edge; spike_count=1; ev_data equals ts at that edge; isi_valid=0; state=ABOVE.
- Glitch rejection: v=4096 for 1 sample, 2048 for 1 sample, repeated 20 times -> no spike, spike_count=0, state stays BELOW.
- Hysteresis and refractory: fire, then v=2048 for 50 cycles -> no re-fire. Then v=-100 -> REFRACT for 16 cycles. Then v=4096 at refractory cycle 10 -> no spike. After REFRACT ends -> spike after 2 samples.
- Periodic firing: square wave v alternating 6000/-6000, 40 cycles each -> isi=80 from the 2nd spike on, isi_valid=1, spike_count increments once per period.
- FIFO: 10 spikes with ev_rd=0 -> 8 entries held, ev_overflow=1, first 8 timestamps read in order. Repeat with a simultaneous pop+push while full -> no overflow.
- Async reset mid-REFRACT with 3 FIFO entries -> all outputs zero, ev_valid=0 without waiting for a clock edge; en=0 freezes the FSM while ts keeps counting.
